// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg: opcode/func constants, state encodings and control codes for the multi-cycle MIPS control unit.
package mc_cu_pkg;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;
  localparam logic [1:0] B_REG  = 2'b00;
  localparam logic [1:0] B_FOUR = 2'b01;
  localparam logic [1:0] B_IMM  = 2'b10;
  localparam logic [1:0] B_BR   = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;
  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  } instr_t;
endpackage

// File: rtl/mc_cu_decode.sv
// mc_cu_decode: combinational one-hot instruction decode; illegal when no instruction matches.
module mc_cu_decode
  import mc_cu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output instr_t     d,
  output logic       ill
);
  logic r;
  assign r = op == OP_R;
  always_comb begin
    d = '0;
    d.i_add  = r & (func == F_ADD);
    d.i_sub  = r & (func == F_SUB);
    d.i_and  = r & (func == F_AND);
    d.i_or   = r & (func == F_OR);
    d.i_xor  = r & (func == F_XOR);
    d.i_sll  = r & (func == F_SLL);
    d.i_srl  = r & (func == F_SRL);
    d.i_sra  = r & (func == F_SRA);
    d.i_jr   = r & (func == F_JR);
    d.i_addi = op == OP_ADDI;
    d.i_andi = op == OP_ANDI;
    d.i_ori  = op == OP_ORI;
    d.i_xori = op == OP_XORI;
    d.i_lw   = op == OP_LW;
    d.i_sw   = op == OP_SW;
    d.i_beq  = op == OP_BEQ;
    d.i_bne  = op == OP_BNE;
    d.i_lui  = op == OP_LUI;
    d.i_j    = op == OP_J;
    d.i_jal  = op == OP_JAL;
    ill = ~|d;
  end
endmodule

// File: rtl/mc_cu.sv
// mc_cu: multi-cycle MIPS control unit with memory handshake timeout and illegal-instruction trap.
// Define MC_CU_PERF_EN to add the icount/ccount performance counters.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
`ifdef MC_CU_PERF_EN
  , parameter int PERF_W    = 32
`endif
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              z,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              iord,
  output logic              wpc,
  output logic              wir,
  output logic              wmem,
  output logic              wreg,
  output logic              regrt,
  output logic              m2reg,
  output logic              jal,
  output logic              sext,
  output logic              shift,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [3:0]        aluc,
  output logic [1:0]        pcsource,
  output logic [2:0]        state,
  output logic              illegal,
  output logic              mem_err
`ifdef MC_CU_PERF_EN
  , output logic [PERF_W-1:0] icount
  , output logic [PERF_W-1:0] ccount
`endif
);
  state_t          st, nst;
  logic [TO_W-1:0] cnt;
  logic            ill_r, merr_r, ill_d, memst, tmo, jmp, alu_r, alu_i, br, taken;
  instr_t          d;
  mc_cu_decode u_dec (.op(op), .func(func), .d(d), .ill(ill_d));
  assign alu_r = d.i_add | d.i_sub | d.i_and | d.i_or | d.i_xor | d.i_sll | d.i_srl | d.i_sra;
  assign alu_i = d.i_addi | d.i_andi | d.i_ori | d.i_xori | d.i_lui;
  assign br    = d.i_beq | d.i_bne;
  assign jmp   = d.i_j | d.i_jal | d.i_jr;
  assign taken = (d.i_beq & z) | (d.i_bne & ~z);
  assign memst = (st == S_IF) | (st == S_MEM);
  assign tmo   = (MEM_TIMEOUT != 0) & memst & ~mem_ready & (cnt == TO_W'(MEM_TIMEOUT));
  assign state = st;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      st     <= S_IF;
      cnt    <= '0;
      ill_r  <= 1'b0;
      merr_r <= 1'b0;
    end else begin
      st     <= nst;
      cnt    <= (nst != st || mem_ready || !memst) ? '0 : cnt + TO_W'(1);
      ill_r  <= ill_r | (st == S_ID && nst == S_TRAP);
      merr_r <= merr_r | tmo;
    end
  always_comb begin
    nst = st;
    case (st)
      S_IF:    nst = mem_ready ? S_ID : tmo ? S_TRAP : S_IF;
      S_ID:    nst = ill_d ? S_TRAP : jmp ? S_IF : S_EXE;
      S_EXE:   nst = (d.i_lw | d.i_sw) ? S_MEM : br ? S_IF : S_WB;
      S_MEM:   nst = mem_ready ? (d.i_sw ? S_IF : S_WB) : tmo ? S_TRAP : S_MEM;
      S_WB:    nst = S_IF;
      default: nst = S_TRAP;
    endcase
  end
  // Everything is gated by resetn so reset assertion kills writes within the same cycle.
  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = B_REG;
    aluc     = ALU_ADD;
    pcsource = PC_ALU;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    if (resetn)
      case (st)
        S_IF: begin
          mem_req = 1'b1;
          alusrca = 1'b1;
          alusrcb = B_FOUR;
          wpc     = mem_ready;
          wir     = mem_ready;
        end
        S_ID: begin
          alusrca  = 1'b1;
          alusrcb  = B_BR;
          sext     = 1'b1;
          wpc      = jmp;
          pcsource = d.i_jr ? PC_REG : (d.i_j | d.i_jal) ? PC_JMP : PC_ALU;
          wreg     = d.i_jal;
          jal      = d.i_jal;
        end
        S_EXE: begin
          alusrcb  = (alu_r | br) ? B_REG : B_IMM;
          sext     = d.i_addi | d.i_lw | d.i_sw;
          shift    = d.i_sll | d.i_srl | d.i_sra;
          aluc     = (d.i_sub) ? ALU_SUB :
                     (d.i_and | d.i_andi) ? ALU_AND :
                     (d.i_or | d.i_ori) ? ALU_OR :
                     (d.i_xor | d.i_xori | br) ? ALU_XOR :
                     d.i_lui ? ALU_LUI :
                     d.i_sll ? ALU_SLL :
                     d.i_srl ? ALU_SRL :
                     d.i_sra ? ALU_SRA : ALU_ADD;
          wpc      = taken;
          pcsource = taken ? PC_OUT : PC_ALU;
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          wmem    = d.i_sw;
        end
        S_WB: begin
          wreg  = 1'b1;
          regrt = alu_i | d.i_lw;
          m2reg = d.i_lw;
        end
        S_TRAP: begin
          illegal = ill_r;
          mem_err = merr_r;
        end
        default: ;
      endcase
  end
`ifdef MC_CU_PERF_EN
  // A retirement is any return to fetch from a working state; trap and fetch stalls do not count.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      icount <= '0;
      ccount <= '0;
    end else begin
      if (st != S_TRAP) ccount <= ccount + PERF_W'(1);
      if (nst == S_IF && st != S_IF && st != S_TRAP) icount <= icount + PERF_W'(1);
    end
`endif
endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: directed plus randomized check of mc_cu against a table-driven instruction-level model.
module tb_mc_cu;
  localparam int TMO = 4;
  logic clock = 1'b0, resetn = 1'b0, z = 1'b0, mem_ready = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic mem_req, iord, wpc, wir, wmem, wreg, regrt, m2reg, jal, sext, shift, alusrca, illegal, mem_err;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;
`ifdef MC_CU_PERF_EN
  logic [31:0] icount, ccount;
`endif
  int compared = 0, mismatched = 0;
  mc_cu #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg),
    .regrt(regrt), .m2reg(m2reg), .jal(jal), .sext(sext), .shift(shift), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state),
    .illegal(illegal), .mem_err(mem_err)
`ifdef MC_CU_PERF_EN
    , .icount(icount), .ccount(ccount)
`endif
  );
  always #5 clock = ~clock;
  // instruction table: 0 add 1 sub 2 and 3 or 4 xor 5 sll 6 srl 7 sra 8 jr 9 addi 10 andi
  // 11 ori 12 xori 13 lw 14 sw 15 beq 16 bne 17 lui 18 j 19 jal
  logic [5:0] tab_op [20] = '{0,0,0,0,0,0,0,0,0,8,12,13,14,35,43,4,5,15,2,3};
  logic [5:0] tab_fn [20] = '{32,34,36,37,38,0,2,3,8,0,0,0,0,0,0,0,0,0,0,0};
  logic [3:0] tab_alu[20] = '{0,4,1,5,2,3,7,15,0,0,1,5,2,0,0,2,2,6,0,0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int lookup(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < 20; i++) if (o == tab_op[i] && (i > 8 || f == tab_fn[i])) return i;
    return -1;
  endfunction
  int ms = 0, cnt = 0, nms, ncnt;
  logic ill = 0, merr = 0, nill, nmerr;
  logic [31:0] ic = 0, cc = 0, nic, ncc;
  always @(negedge clock) begin
    int k;
    logic emr, eio, ewpc, ewir, ewm, ewr, ert, em2, ej, esx, esh, ea, eil, eme;
    logic [1:0] eb, ep;
    logic [3:0] eal;
    {emr, eio, ewpc, ewir, ewm, ewr, ert, em2, ej, esx, esh, ea, eil, eme} = '0;
    eb = 0; ep = 0; eal = 0;
    k = lookup(op, func);
    nms = 0; nill = ill; nmerr = merr;
    if (resetn)
      case (ms)
        0, 3: begin
          emr = 1; eio = ms == 3; ewm = ms == 3 && k == 14;
          if (ms == 0) begin ea = 1; eb = 1; end
          if (mem_ready) begin ewpc = ms == 0; ewir = ms == 0; nms = ms == 0 ? 1 : k == 14 ? 0 : 4; end
          else if (cnt == TMO) begin nms = 7; nmerr = 1; end
          else nms = ms;
        end
        1: begin
          ea = 1; eb = 3; esx = 1;
          if (k < 0) begin nms = 7; nill = 1; end
          else if (k == 18 || k == 19) begin ewpc = 1; ep = 3; ewr = k == 19; ej = k == 19; nms = 0; end
          else if (k == 8) begin ewpc = 1; ep = 2; nms = 0; end
          else nms = 2;
        end
        2: begin
          if (k <= 7) begin eal = tab_alu[k]; esh = k >= 5; nms = 4; end
          else if (k == 15 || k == 16) begin
            eal = 2; ewpc = (k == 15) ? z : !z; ep = ewpc ? 1 : 0; nms = 0;
          end else begin eb = 2; eal = tab_alu[k]; esx = k == 9 || k == 13 || k == 14; nms = (k == 13 || k == 14) ? 3 : 4; end
        end
        4: begin ewr = 1; ert = k >= 9; em2 = k == 13; nms = 0; end
        default: begin eil = ill; eme = merr; nms = 7; end
      endcase
    ncnt = (resetn && (ms == 0 || ms == 3) && !mem_ready && nms == ms) ? cnt + 1 : 0;
    ncc = cc + ((ms != 7) ? 1 : 0);
    nic = ic + ((nms == 0 && ms >= 1 && ms <= 4) ? 1 : 0);
    chk("state", state, resetn ? ms : 0);
    chk("ctl", {mem_req, iord, wpc, wir, wmem, wreg, regrt, m2reg, jal, sext, shift, alusrca, alusrcb, aluc, pcsource, illegal, mem_err},
        {emr, eio, ewpc, ewir, ewm, ewr, ert, em2, ej, esx, esh, ea, eb, eal, ep, eil, eme});
`ifdef MC_CU_PERF_EN
    chk("icount", icount, resetn ? ic : 0);
    chk("ccount", ccount, resetn ? cc : 0);
`endif
  end
  always @(posedge clock)
    if (!resetn) begin ms <= 0; cnt <= 0; ill <= 0; merr <= 0; ic <= 0; cc <= 0; end
    else begin ms <= nms; cnt <= ncnt; ill <= nill; merr <= nmerr; ic <= nic; cc <= ncc; end
  task automatic step();
    @(posedge clock);
    #2;
  endtask
  int addseq[4] = '{1, 2, 4, 0};
  initial begin
    mem_ready = 1; func = 6'h20;
    repeat (2) step();
    chk("rst_state", state, 0);
    chk("rst_memreq", mem_req, 0);
    resetn = 1;
    #1 chk("if_memreq", mem_req, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("add_state", state, addseq[i]);
      chk("add_wreg", wreg, addseq[i] == 4);
    end
`ifdef MC_CU_PERF_EN
    chk("add_icount", icount, 1);
`endif
    op = 6'h03; func = 6'h15;
    step();
    chk("jal_id", {state, wpc, pcsource, wreg, jal}, {3'd1, 1'b1, 2'b11, 1'b1, 1'b1});
    step();
    chk("jal_done", state, 0);
    op = 6'h23;
    step(); step(); mem_ready = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem", {state, mem_req, iord}, {3'd3, 1'b1, 1'b1});
      if (i == 3) mem_ready = 1;
      step();
    end
    chk("lw_wb", {state, wreg, m2reg}, {3'd4, 1'b1, 1'b1});
    step();
    chk("lw_done", state, 0);
    op = 6'h04; z = 1;
    step(); step();
    chk("beq_taken", {state, wpc, pcsource}, {3'd2, 1'b1, 2'b01});
    step();
    chk("beq_t_if", state, 0);
    z = 0;
    step(); step();
    chk("beq_not", {state, wpc, pcsource}, {3'd2, 1'b0, 2'b00});
    step();
    chk("beq_n_if", state, 0);
    op = 6'h2b;
    step(); step(); mem_ready = 0;
    step();
    chk("sw_wmem", wmem, 1);
    #1 resetn = 0;
    #1 chk("sw_rst", {state, wmem, mem_req}, 0);
    step();
    resetn = 1;
    #1 chk("sw_after", state, 0);
`ifdef MC_CU_PERF_EN
    chk("sw_cnt", {icount, ccount}, 0);
`endif
    op = 6'h3f; mem_ready = 1;
    step(); step();
    chk("ill_trap", {state, illegal, mem_err, mem_req}, {3'd7, 1'b1, 1'b0, 1'b0});
    step();
    chk("ill_hold", {state, mem_req}, {3'd7, 1'b0});
    resetn = 0; mem_ready = 0;
    step();
    resetn = 1;
    repeat (4) step();
    chk("tmo_wait", state, 0);
    step();
    chk("tmo_trap", {state, mem_err, illegal}, {3'd7, 1'b1, 1'b0});
    for (int c = 0; c < 4000; c++) begin
      step();
      if (ms == 7 || $urandom_range(0, 299) == 0) begin
        resetn = 0;
        step();
        resetn = 1;
      end
      mem_ready = $urandom_range(0, 2) != 0;
      z = 1'($urandom);
      if (ms == 0) begin
        int r;
        r = $urandom_range(0, 21);
        if (r < 20) begin op = tab_op[r]; func = r < 9 ? tab_fn[r] : 6'($urandom); end
        else begin op = 6'($urandom); func = 6'($urandom); end
      end
    end
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
